// File: rtl/session_timeout_ctrl_pkg.sv
// Shared types and widths for the session timeout controller.
package session_pkg;

    localparam int ID_W    = 5;
    localparam int SECS_W  = 8;
    localparam int USAGE_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        WARN     = 3'd2,
        EXPIRE   = 3'd3,
        WAIT_OUT = 3'd4
    } sessionState_e;

    function automatic logic [USAGE_W-1:0] satInc(input logic [USAGE_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/session_timeout_ctrl_if.sv
// Auth-stage / game-controller signal bundle for the session timeout controller.
interface session_timeout_ctrl_if;
    import session_pkg::*;

    logic                LogIn;
    logic [ID_W-1:0]     InternalID;
    logic                Activity;
    logic                Quit;
    logic                GCLogOut;
    logic [ID_W-1:0]     SessionID;
    logic [SECS_W-1:0]   SecsLeft;
    logic                Warn;
    logic                Active;
    logic [USAGE_W-1:0]  UsageCount;

    modport master (
        output LogIn, InternalID, Activity, Quit,
        input  GCLogOut, SessionID, SecsLeft, Warn, Active, UsageCount
    );

    modport slave (
        input  LogIn, InternalID, Activity, Quit,
        output GCLogOut, SessionID, SecsLeft, Warn, Active, UsageCount
    );

endinterface

// File: rtl/session_timeout_ctrl_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/session_timeout_ctrl.sv
// Per-session inactivity timer issuing GCLogOut to the auth stage.
// Optional per-ID login counter enabled by defining SESSION_USAGE_EN.
module session_timeout_ctrl
    import session_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SESSION_SEC = 60,
    parameter int WARN_SEC    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    session_timeout_ctrl_if.slave sess
);
    localparam logic [SECS_W-1:0] SESSION_SECS = SECS_W'(SESSION_SEC);
    localparam logic [SECS_W-1:0] WARN_SECS    = SECS_W'(WARN_SEC);

    sessionState_e     state, nextState;
    logic [SECS_W-1:0] secsLeft, secsNext, secsDec;
    logic [ID_W-1:0]   sessionId;
    logic              running, tick, prescalerClear, startSession;

    assign running = (state == RUN) || (state == WARN);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (running),
        .clear  (prescalerClear),
        .tick   (tick)
    );

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        nextState      = state;
        secsNext       = secsLeft;
        secsDec        = (secsLeft == '0) ? '0 : secsLeft - 1'b1;
        prescalerClear = !running;
        startSession   = 1'b0;
        unique case (state)
            IDLE: begin
                if (sess.LogIn) begin
                    nextState    = RUN;
                    secsNext     = SESSION_SECS;
                    startSession = 1'b1;
                end
            end
            RUN, WARN: begin
                // External logout outranks quit and expiry: auth already knows.
                if (!sess.LogIn) begin
                    nextState = IDLE;
                    secsNext  = '0;
                end else if (sess.Quit) begin
                    nextState = EXPIRE;
                end else if (sess.Activity) begin
                    nextState      = RUN;
                    secsNext       = SESSION_SECS;
                    prescalerClear = 1'b1;
                end else if (tick) begin
                    secsNext = secsDec;
                    if (secsDec == '0) begin
                        nextState = EXPIRE;
                    end else if (secsDec <= WARN_SECS) begin
                        nextState = WARN;
                    end
                end
            end
            EXPIRE:   nextState = WAIT_OUT;
            WAIT_OUT: if (!sess.LogIn) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            secsLeft  <= '0;
            sessionId <= '0;
        end else begin
            state    <= nextState;
            secsLeft <= secsNext;
            if (startSession) sessionId <= sess.InternalID;
        end
    end

    assign sess.GCLogOut  = (state == EXPIRE);
    assign sess.Active    = running;
    assign sess.Warn      = (state == WARN);
    assign sess.SessionID = sessionId;
    assign sess.SecsLeft  = secsLeft;

`ifdef SESSION_USAGE_EN
    logic [USAGE_W-1:0] usageTable [1 << ID_W];
    logic [USAGE_W-1:0] usageCount;

    // NOTE: the table is small and must read as zero after reset, so it is built from resettable flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < (1 << ID_W); i++) usageTable[i] <= '0;
            usageCount <= '0;
        end else if (startSession) begin
            usageTable[sess.InternalID] <= satInc(usageTable[sess.InternalID]);
            usageCount                  <= satInc(usageTable[sess.InternalID]);
        end else begin
            usageCount <= usageTable[sessionId];
        end
    end

    assign sess.UsageCount = usageCount;
`else
    assign sess.UsageCount = '0;
`endif

endmodule

// File: tb/tb_session_timeout_ctrl.sv
// Directed plus randomized bench for session_timeout_ctrl against a time-based session model.
module tb_session_timeout_ctrl;
    import session_pkg::*;

    localparam int TICK_DIV    = 4;
    localparam int SESSION_SEC = 5;
    localparam int WARN_SEC    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    session_timeout_ctrl_if sess();

    session_timeout_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .SESSION_SEC (SESSION_SEC),
        .WARN_SEC    (WARN_SEC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sess (sess)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;

    // Model: a session is a window that starts at the last refresh edge; seconds left
    // follow from elapsed cycles, expiry occurs once a full SESSION_SEC has elapsed.
    int nowCyc, refreshCyc, mId, mSecsVal;
    bit mIn, mPulse, mWait, mSecsKnown;
    int mUsage [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int modelSecs();
        return mIn ? SESSION_SEC - (nowCyc - refreshCyc) / TICK_DIV : mSecsVal;
    endfunction

    task automatic modelReset();
        nowCyc = 0; refreshCyc = 0; mId = 0; mSecsVal = 0;
        mIn = 0; mPulse = 0; mWait = 0; mSecsKnown = 1;
        for (int i = 0; i < 32; i++) mUsage[i] = 0;
    endtask

    task automatic modelEdge(input bit li, input int id, input bit act, input bit qt);
        nowCyc++;
        if (mPulse) begin
            mPulse = 0;
        end else if (mWait) begin
            if (!li) mWait = 0;
        end else if (!mIn) begin
            if (li) begin
                mIn = 1; refreshCyc = nowCyc; mId = id;
                if (mUsage[id] < 255) mUsage[id]++;
            end
        end else if (!li) begin
            mIn = 0; mSecsKnown = 1; mSecsVal = 0;
        end else if (qt) begin
            mIn = 0; mPulse = 1; mWait = 1; mSecsKnown = 0;
        end else if (act) begin
            refreshCyc = nowCyc;
        end else if (nowCyc - refreshCyc >= SESSION_SEC * TICK_DIV) begin
            mIn = 0; mPulse = 1; mWait = 1; mSecsKnown = 1; mSecsVal = 0;
        end
    endtask

    task automatic compareAll(input string tag);
        int expUsage;
`ifdef SESSION_USAGE_EN
        expUsage = mUsage[mId];
`else
        expUsage = 0;
`endif
        check($sformatf("%s.gc", tag),     sess.GCLogOut,  mPulse);
        check($sformatf("%s.active", tag), sess.Active,    mIn);
        check($sformatf("%s.warn", tag),   sess.Warn,      mIn && (modelSecs() <= WARN_SEC));
        check($sformatf("%s.id", tag),     sess.SessionID, mId);
        check($sformatf("%s.usage", tag),  sess.UsageCount, expUsage);
        if (mIn || mSecsKnown) check($sformatf("%s.secs", tag), sess.SecsLeft, modelSecs());
    endtask

    task automatic cycle(input bit li, input int id, input bit act, input bit qt, input string tag);
        sess.LogIn = li; sess.InternalID = 5'(id); sess.Activity = act; sess.Quit = qt;
        @(posedge clk);
        #1;
        modelEdge(li, id, act, qt);
        compareAll(tag);
    endtask

    task automatic checkAllZero(input string tag);
        check($sformatf("%s.gc", tag),     sess.GCLogOut,   0);
        check($sformatf("%s.active", tag), sess.Active,     0);
        check($sformatf("%s.warn", tag),   sess.Warn,       0);
        check($sformatf("%s.id", tag),     sess.SessionID,  0);
        check($sformatf("%s.secs", tag),   sess.SecsLeft,   0);
        check($sformatf("%s.usage", tag),  sess.UsageCount, 0);
    endtask

    initial begin
        int actRate;
        sess.LogIn = 0; sess.InternalID = 0; sess.Activity = 0; sess.Quit = 0;
        modelReset();
        #1 rst = 1'b0;
        #2 checkAllZero("por");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        cycle(0, 0, 0, 0, "idle");

        // Login and countdown into warning
        cycle(1, 7, 0, 0, "login");
        check("login.active", sess.Active, 1);
        check("login.id", sess.SessionID, 7);
        check("login.secs", sess.SecsLeft, 5);
        repeat (11) cycle(1, 7, 0, 0, "run");
        check("prewarn.secs", sess.SecsLeft, 3);
        check("prewarn.warn", sess.Warn, 0);
        cycle(1, 7, 0, 0, "warn");
        check("warn.secs", sess.SecsLeft, 2);
        check("warn.warn", sess.Warn, 1);

        // Timeout, single pulse, hold in WAIT_OUT
        repeat (7) cycle(1, 7, 0, 0, "count");
        check("pre_to.secs", sess.SecsLeft, 1);
        check("pre_to.gc", sess.GCLogOut, 0);
        cycle(1, 7, 0, 0, "timeout");
        check("timeout.gc", sess.GCLogOut, 1);
        check("timeout.secs", sess.SecsLeft, 0);
        check("timeout.active", sess.Active, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 7, (i == 1), (i == 2), "hold");
            check("hold.gc", sess.GCLogOut, 0);
        end
        cycle(0, 7, 0, 0, "release");
        cycle(0, 7, 0, 0, "idle2");
        check("idle2.active", sess.Active, 0);

        // Activity refresh at 1 s left, then Activity coinciding with a tick
        cycle(1, 3, 0, 0, "login3");
        repeat (16) cycle(1, 3, 0, 0, "run3");
        check("low.secs", sess.SecsLeft, 1);
        cycle(1, 3, 1, 0, "act");
        check("act.secs", sess.SecsLeft, 5);
        check("act.warn", sess.Warn, 0);
        repeat (3) cycle(1, 3, 0, 0, "pretick");
        cycle(1, 3, 1, 0, "act_tick");
        check("act_tick.secs", sess.SecsLeft, 5);
        repeat (3) cycle(1, 3, 0, 0, "posttick");
        check("posttick.secs", sess.SecsLeft, 5);
        cycle(1, 3, 0, 0, "nexttick");
        check("nexttick.secs", sess.SecsLeft, 4);

        // Quit beats Activity
        cycle(1, 3, 1, 1, "quit_act");
        check("quit_act.gc", sess.GCLogOut, 1);
        check("quit_act.active", sess.Active, 0);
        cycle(1, 3, 0, 0, "quit_wait");
        cycle(0, 3, 0, 0, "quit_rel");
        cycle(0, 3, 0, 0, "quit_idle");

        // Second login of ID 3; Quit with LogIn falling gives no pulse
        cycle(1, 3, 0, 0, "relogin3");
`ifdef SESSION_USAGE_EN
        check("relogin3.usage", sess.UsageCount, 2);
`else
        check("relogin3.usage", sess.UsageCount, 0);
`endif
        repeat (2) cycle(1, 3, 0, 0, "run3b");
        cycle(0, 3, 0, 1, "quit_drop");
        check("quit_drop.gc", sess.GCLogOut, 0);
        check("quit_drop.secs", sess.SecsLeft, 0);
        cycle(0, 3, 0, 0, "quit_drop2");
        check("quit_drop2.gc", sess.GCLogOut, 0);

        // LogIn falls on the expiry edge
        cycle(1, 4, 0, 0, "login4");
        repeat (19) cycle(1, 4, 0, 0, "run4");
        cycle(0, 4, 0, 0, "drop_expiry");
        check("drop_expiry.gc", sess.GCLogOut, 0);
        cycle(0, 4, 0, 0, "drop_expiry2");
        check("drop_expiry2.gc", sess.GCLogOut, 0);

        // InternalID changes mid-session are ignored, then async reset aborts
        cycle(1, 20, 0, 0, "login20");
        cycle(1, 9, 0, 0, "idchg");
        cycle(1, 11, 1, 0, "idchg_act");
        check("idchg.id", sess.SessionID, 20);
        #2 rst = 1'b0;
        #1 checkAllZero("midreset");
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1, 9, 0, 0, "postreset");
        cycle(0, 9, 0, 0, "postreset_out");
        check("postreset.gc", sess.GCLogOut, 0);
        cycle(0, 9, 0, 0, "postreset_idle");

        // Randomized traffic
        actRate = 6;
        for (int n = 0; n < 2000; n++) begin
            if (n % 250 == 0) actRate = (actRate == 6) ? 1 : 6;
            cycle($urandom_range(99, 0) < 93, $urandom_range(31, 0),
                  $urandom_range(99, 0) < actRate, $urandom_range(99, 0) < 2, "rand");
        end
        repeat (3) cycle(0, 0, 0, 0, "drain");

        // Usage saturation for ID 12
        for (int n = 0; n < 256; n++) begin
            cycle(1, 12, 0, 0, "sat_in");
            cycle(0, 12, 0, 0, "sat_out");
        end
`ifdef SESSION_USAGE_EN
        check("sat.usage", sess.UsageCount, 255);
`else
        check("sat.usage", sess.UsageCount, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
